// File: rtl/reset_pkg.sv
// Shared definitions for the staged reset-release sequencer: FSM encodings and
// the sizing helper for its single shared counter.
package reset_pkg;

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    RELEASE  = 3'd1,
    WAIT_ACK = 3'd2,
    WAIT_DLY = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } seq_state_t;

  // The counter has to reach the largest of the three programmable intervals.
  function automatic int cnt_width(input int hold, input int dly, input int tmo);
    int m;
    m = hold;
    if (dly > m) m = dly;
    if (tmo > m) m = tmo;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bank with asynchronous active-low clear, used to bring
// the per-stage ready acknowledgements into the clk domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_p0 <= '0;
      q       <= '0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/reset_seq.sv
// Staged reset-release sequencer: holds all subsystem resets, then releases them
// in order 0..N-1 with fixed spacing and optional per-stage ready handshakes.
module reset_seq
  import reset_pkg::*;
#(
  parameter int                  N_STAGES    = 4,
  parameter int                  HOLD_CYCLES = 32,
  parameter int                  STAGE_DELAY = 16,
  parameter int                  ACK_TIMEOUT = 1024,
  parameter logic [N_STAGES-1:0] USE_ACK     = '0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                soft_rst_req,
  input  logic [N_STAGES-1:0] stage_ack,
  output logic [N_STAGES-1:0] stage_resetn,
  output logic                seq_done,
  output logic                seq_err,
  output logic [3:0]          cur_stage
);

  localparam int              CNT_W     = cnt_width(HOLD_CYCLES, STAGE_DELAY, ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [15:0]      USE_PAD   = 16'(USE_ACK);
  localparam logic [3:0]       LAST_IDX  = 4'(N_STAGES - 1);

  logic [N_STAGES-1:0] ack_s;
  logic [15:0]         ack_pad;
  seq_state_t          state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [N_STAGES-1:0] stage_nxt;
  logic                done_nxt, err_nxt, release_now;
  logic [3:0]          cur_nxt, rel_idx;

  sync_2ff #(.WIDTH(N_STAGES)) u_ack_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (stage_ack),
    .q      (ack_s)
  );

  assign ack_pad = 16'(ack_s);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Where the FSM goes once stage idx has just been released.
  function automatic seq_state_t after_release(input logic [3:0] idx);
    if (idx == LAST_IDX)  return DONE;
    else if (USE_PAD[idx]) return WAIT_ACK;
    else                   return RELEASE;
  endfunction

  // RELEASE counts the spacing after a plain release; WAIT_DLY counts the
  // spacing after an acknowledged release. Both start from 0 on their entry edge.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = sat_inc(cnt);
    stage_nxt   = stage_resetn;
    done_nxt    = seq_done;
    err_nxt     = seq_err;
    cur_nxt     = cur_stage;
    release_now = 1'b0;
    rel_idx     = (state == HOLD) ? 4'd0 : cur_stage + 4'd1;

    case (state)
      HOLD:              release_now = (cnt == HOLD_LAST);
      RELEASE, WAIT_DLY: release_now = (cnt == DLY_LAST);
      WAIT_ACK: begin
        if (ack_pad[cur_stage]) begin
          state_nxt = WAIT_DLY;
        end else if (cnt == TMO_LAST) begin
          state_nxt = ERR;
          err_nxt   = 1'b1;
        end
      end
      DONE:    done_nxt = 1'b1;
      default: ;
    endcase

    if (release_now) begin
      stage_nxt = (stage_resetn << 1) | N_STAGES'(1);
      cur_nxt   = rel_idx;
      state_nxt = after_release(rel_idx);
    end

    if (release_now || (state_nxt != state)) cnt_nxt = '0;

    if (soft_rst_req) begin
      state_nxt = HOLD;
      cnt_nxt   = '0;
      stage_nxt = '0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      cur_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= HOLD;
      cnt          <= '0;
      stage_resetn <= '0;
      seq_done     <= 1'b0;
      seq_err      <= 1'b0;
      cur_stage    <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      stage_resetn <= stage_nxt;
      seq_done     <= done_nxt;
      seq_err      <= err_nxt;
      cur_stage    <= cur_nxt;
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: four instances cover the default sequence, ack
// handshake, ack timeout and the single-stage corner.
module tb_reset_seq;

  logic clk;
  int   vectors;
  int   miscompares;

  // a: defaults, no acks
  logic       rstn_a, soft_a;
  logic [3:0] ack_a, st_a, cur_a;
  logic       done_a, err_a;
  // b: stage 1 waits for ack[1]
  logic       rstn_b, soft_b;
  logic [3:0] ack_b, st_b, cur_b;
  logic       done_b, err_b;
  // c: stage 0 waits for ack[0]
  logic       rstn_c, soft_c;
  logic [3:0] ack_c, st_c, cur_c;
  logic       done_c, err_c;
  // d: single stage, minimal timing
  logic       rstn_d, soft_d;
  logic [0:0] ack_d, st_d;
  logic [3:0] cur_d;
  logic       done_d, err_d;

  reset_seq dut_a (
    .clk(clk), .resetn(rstn_a), .soft_rst_req(soft_a), .stage_ack(ack_a),
    .stage_resetn(st_a), .seq_done(done_a), .seq_err(err_a), .cur_stage(cur_a)
  );

  reset_seq #(.USE_ACK(4'b0010)) dut_b (
    .clk(clk), .resetn(rstn_b), .soft_rst_req(soft_b), .stage_ack(ack_b),
    .stage_resetn(st_b), .seq_done(done_b), .seq_err(err_b), .cur_stage(cur_b)
  );

  reset_seq #(.USE_ACK(4'b0001)) dut_c (
    .clk(clk), .resetn(rstn_c), .soft_rst_req(soft_c), .stage_ack(ack_c),
    .stage_resetn(st_c), .seq_done(done_c), .seq_err(err_c), .cur_stage(cur_c)
  );

  reset_seq #(.N_STAGES(1), .HOLD_CYCLES(1), .STAGE_DELAY(1), .USE_ACK(1'b0)) dut_d (
    .clk(clk), .resetn(rstn_d), .soft_rst_req(soft_d), .stage_ack(ack_d),
    .stage_resetn(st_d), .seq_done(done_d), .seq_err(err_d), .cur_stage(cur_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected thermometer code k edges after release for HOLD=32, DELAY=16, 4 stages.
  function automatic logic [3:0] exp_default(input int k);
    int up;
    if (k < 32) up = 0;
    else        up = (k - 32) / 16 + 1;
    if (up > 4) up = 4;
    return 4'((1 << up) - 1);
  endfunction

  // Checks a default-timing sequence for edges 1..last, k counted from the
  // edge that ended reset (or sampled the soft request).
  task automatic run_default_a(input string tag, input int last);
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (st_a !== exp_default(k)) begin
        miscompares++;
        $display("FAIL %s_stage k=%0d got %b want %b", tag, k, st_a, exp_default(k));
      end
      vectors++;
      if (done_a !== (k >= 81)) begin
        miscompares++;
        $display("FAIL %s_done k=%0d got %b want %b", tag, k, done_a, (k >= 81));
      end
      vectors++;
      if (err_a !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_err k=%0d got %b want 0", tag, k, err_a);
      end
    end
  endtask

  task automatic test_reset;
    rstn_a = 0; rstn_b = 0; rstn_c = 0; rstn_d = 0;
    soft_a = 0; soft_b = 0; soft_c = 0; soft_d = 0;
    ack_a = '0; ack_b = '0; ack_c = '0; ack_d = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({st_a, done_a, err_a, cur_a} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_a got st=%b done=%b err=%b cur=%0d want all 0", st_a, done_a, err_a, cur_a);
    end
    vectors++;
    if ({st_d, done_d, err_d, cur_d} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_d got st=%b done=%b err=%b cur=%0d want all 0", st_d, done_d, err_d, cur_d);
    end
  endtask

  task automatic test_release;
    @(negedge clk); rstn_a = 1;
    run_default_a("t1", 90);
    vectors++;
    if (cur_a !== 4'd3) begin
      miscompares++;
      $display("FAIL t1_cur got %0d want 3", cur_a);
    end
  endtask

  task automatic test_soft_restart;
    @(negedge clk); soft_a = 1;
    @(posedge clk); #1;
    soft_a = 0;
    vectors++;
    if (st_a !== 4'b0000) begin
      miscompares++;
      $display("FAIL t4_clear_stage got %b want 0000", st_a);
    end
    vectors++;
    if (done_a !== 1'b0) begin
      miscompares++;
      $display("FAIL t4_clear_done got %b want 0", done_a);
    end
    run_default_a("t4", 90);
  endtask

  task automatic test_async_reset;
    @(negedge clk); rstn_a = 0;
    @(negedge clk); rstn_a = 1;
    for (int k = 1; k <= 50; k++) @(posedge clk);
    #1;
    vectors++;
    if (st_a !== 4'b0011) begin
      miscompares++;
      $display("FAIL t5_pre got %b want 0011", st_a);
    end
    #2 rstn_a = 0;
    #1;
    vectors++;
    if ({st_a, done_a, cur_a} !== 9'b0) begin
      miscompares++;
      $display("FAIL t5_async got st=%b done=%b cur=%0d want 0", st_a, done_a, cur_a);
    end
    @(negedge clk);
    @(negedge clk); rstn_a = 1;
    run_default_a("t5", 85);
  endtask

  task automatic test_ack_handshake;
    logic [3:0] exp;
    @(negedge clk); rstn_b = 1;
    for (int k = 1; k <= 195; k++) begin
      @(posedge clk); #1;
      if      (k < 32)  exp = 4'b0000;
      else if (k < 48)  exp = 4'b0001;
      else if (k < 167) exp = 4'b0011;
      else if (k < 183) exp = 4'b0111;
      else              exp = 4'b1111;
      vectors++;
      if (st_b !== exp) begin
        miscompares++;
        $display("FAIL t2_stage k=%0d got %b want %b", k, st_b, exp);
      end
      vectors++;
      if (done_b !== (k >= 184)) begin
        miscompares++;
        $display("FAIL t2_done k=%0d got %b want %b", k, done_b, (k >= 184));
      end
      if (k == 148) begin
        @(negedge clk); ack_b = 4'b0010;
      end
      if (k == 175) begin
        @(negedge clk); ack_b = 4'b0000;
      end
    end
    vectors++;
    if (err_b !== 1'b0) begin
      miscompares++;
      $display("FAIL t2_err got %b want 0", err_b);
    end
  endtask

  task automatic test_ack_timeout;
    @(negedge clk); rstn_c = 1;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (st_c !== ((k >= 32) ? 4'b0001 : 4'b0000)) begin
        miscompares++;
        $display("FAIL t3_stage k=%0d got %b want %b", k, st_c, ((k >= 32) ? 4'b0001 : 4'b0000));
      end
      vectors++;
      if (err_c !== (k >= 1056)) begin
        miscompares++;
        $display("FAIL t3_err k=%0d got %b want %b", k, err_c, (k >= 1056));
      end
    end
    vectors++;
    if ({done_c, cur_c} !== 5'b0) begin
      miscompares++;
      $display("FAIL t3_done_cur got done=%b cur=%0d want 0 0", done_c, cur_c);
    end
    @(negedge clk); soft_c = 1;
    @(posedge clk); #1;
    soft_c = 0;
    vectors++;
    if ({st_c, err_c} !== 5'b0) begin
      miscompares++;
      $display("FAIL t3_soft_clear got st=%b err=%b want 0000 0", st_c, err_c);
    end
    for (int k = 1; k <= 32; k++) @(posedge clk);
    #1;
    vectors++;
    if (st_c !== 4'b0001) begin
      miscompares++;
      $display("FAIL t3_rerun got %b want 0001", st_c);
    end
  endtask

  task automatic test_single_stage;
    @(negedge clk); rstn_d = 1;
    @(posedge clk); #1;
    vectors++;
    if ({st_d, done_d} !== 2'b10) begin
      miscompares++;
      $display("FAIL t6_edge1 got st=%b done=%b want 1 0", st_d, done_d);
    end
    @(posedge clk); #1;
    vectors++;
    if ({st_d, done_d} !== 2'b11) begin
      miscompares++;
      $display("FAIL t6_edge2 got st=%b done=%b want 1 1", st_d, done_d);
    end
    @(negedge clk); soft_d = 1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      vectors++;
      if ({st_d, done_d} !== 2'b00) begin
        miscompares++;
        $display("FAIL t6_soft_hold k=%0d got st=%b done=%b want 0 0", k, st_d, done_d);
      end
    end
    @(negedge clk); soft_d = 0;
    @(posedge clk); #1;
    vectors++;
    if ({st_d, done_d} !== 2'b10) begin
      miscompares++;
      $display("FAIL t6_after_soft got st=%b done=%b want 1 0", st_d, done_d);
    end
    @(posedge clk); #1;
    vectors++;
    if (done_d !== 1'b1) begin
      miscompares++;
      $display("FAIL t6_done got %b want 1", done_d);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_release();
    test_soft_restart();
    test_async_reset();
    test_ack_handshake();
    test_ack_timeout();
    test_single_stage();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
